// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and sizes for the round-robin bus arbiter.
// Four requesters share a single 2-bit mux select.
package rr_bus_arbiter_pkg;

    localparam int REQ_N = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_bus_arbiter_mux.sv
// 4:1 datapath mux steered by the arbiter's registered select.
// Purely combinational.
module rr_bus_arbiter_mux
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data
);

    always_comb begin
        out_data = in0;
        unique case (sel)
            2'd0: out_data = in0;
            2'd1: out_data = in1;
            2'd2: out_data = in2;
            2'd3: out_data = in3;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 datapath mux.
// Holds a grant until last, abandon or burst cap, then rotates priority.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REQ_N-1:0] req,
    input  logic [REQ_N-1:0] last,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [REQ_N-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [3:0] CAP = 4'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [REQ_N-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] idx;
    logic             found;
    logic             beat;
    logic             release_grant;
    logic [3:0]       cnt_inc;

    // Scan from ptr upward so the last winner has lowest priority.
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = ptr_q + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign out_valid = (|gnt_q) && req[sel_q];
    assign beat      = out_valid && out_ready;
    assign cnt_inc   = (beat_cnt_q == CAP) ? beat_cnt_q : beat_cnt_q + 4'd1;
    assign release_grant = !req[sel_q]
                        || (beat && (last[sel_q] || cnt_inc == CAP));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d      = REQ_N'(1) << win;
                    sel_d      = win;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (beat) beat_cnt_d = cnt_inc;
                if (release_grant) begin
                    gnt_d   = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == BUSY);

    rr_bus_arbiter_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .in0     (in0),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .sel     (sel_q),
        .out_data(out_data)
    );

endmodule
